// File: rtl/led_fade_ctrl.sv
// Fade scheduler: ramps a PWM duty value one LSB per STEP_TICKS ticks toward a commanded target,
// holds for HOLD_TICKS ticks, then pulses done. Define LED_FADE_LOOP_EN for endless breathing mode.
module led_fade_ctrl #(
  parameter int DUTY_W     = 4,
  parameter int STEP_TICKS = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_target,
  output logic              cmd_ready,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  localparam int MAX_TICKS = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] step_duty;
  logic              step_last;
  logic              hold_last;
`ifdef LED_FADE_LOOP_EN
  // The origin is only needed to reverse the fade in breathing mode.
  logic [DUTY_W-1:0] org_q, org_d;
`endif

  // Moving one LSB toward the target can never overshoot or wrap, since RAMP implies duty != target.
  always_comb begin
    step_duty = duty_q;
    if (tgt_q > duty_q) begin
      step_duty = duty_q + 1'b1;
    end else if (tgt_q < duty_q) begin
      step_duty = duty_q - 1'b1;
    end
  end

  assign step_last = tick && (cnt_q == STEP_LAST);
  assign hold_last = tick && (cnt_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      duty_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_FADE_LOOP_EN
      org_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LED_FADE_LOOP_EN
      org_q   <= org_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_target == duty_q) ? HOLD : RAMP;
        end
      end
      RAMP: begin
        if (step_last && (step_duty == tgt_q)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_last) begin
`ifdef LED_FADE_LOOP_EN
          state_d = (org_q == tgt_q) ? HOLD : RAMP;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tgt_d  = tgt_q;
    duty_d = duty_q;
    done_d = 1'b0;
`ifdef LED_FADE_LOOP_EN
    org_d  = org_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A tick arriving with the command is deliberately dropped.
        if (cmd_valid) begin
          tgt_d = cmd_target;
          cnt_d = '0;
`ifdef LED_FADE_LOOP_EN
          org_d = duty_q;
`endif
        end
      end
      RAMP: begin
        if (step_last) begin
          cnt_d  = '0;
          duty_d = step_duty;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (hold_last) begin
          cnt_d  = '0;
          done_d = 1'b1;
`ifdef LED_FADE_LOOP_EN
          tgt_d  = org_q;
          org_d  = tgt_q;
`endif
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
    if (abort) begin
      cnt_d  = '0;
      duty_d = duty_q;
      done_d = 1'b0;
      tgt_d  = tgt_q;
`ifdef LED_FADE_LOOP_EN
      org_d  = org_q;
`endif
    end
    busy_d = (state_d != IDLE);
  end

  assign cmd_ready = (state_q == IDLE);
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
